alu_serial_ctrl: RTL and testbench
==================================

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter: W, default 8, operand/result width in bits (W >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_op  input  4  opcode, same encoding as the 1-bit ALU CTRL field.
REQ-007 req_a, req_b  input  W each  operands.
REQ-008 alu_a, alu_b  output  1 each  bit driven to the external 1-bit ALU.
REQ-009 alu_ctrl  output  4  opcode driven to the external 1-bit ALU.
REQ-010 alu_y  input  2  combinational ALU result for the current bit.
REQ-011 rsp_valid  output  1  response held.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_result  output  W  assembled result.
REQ-014 rsp_carry  output  1  final carry (ADD) or borrow (SUB); 0 otherwise.
REQ-015 rsp_err  output  1  opcode rejected.

Function
REQ-016 FSM states IDLE, RUN, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE: req_valid=1 with supported op captures op, a, b; carry/borrow cleared; bit index = 0; -> RUN.
REQ-018 IDLE: req_valid=1 with unsupported op -> RESP next cycle, rsp_err=1, rsp_result=0, rsp_carry=0, no RUN cycles.
REQ-019 Supported ops: 0000-0110 (AND, OR, NOT A, NAND, NOR, XOR, XNOR); 0111 ADD and 1000 SUB per REQ-031; 1001-1111 unsupported.
REQ-020 RUN: one bit per cycle LSB first; alu_a/alu_b = captured bit i, alu_ctrl = captured op; alu_y sampled same cycle.
REQ-021 Bitwise ops: result bit i = alu_y[0].
REQ-022 ADD: bit i = alu_y[0] ^ c; c_next = alu_y[1] | (alu_y[0] & c).
REQ-023 SUB: bit i = alu_y[0] ^ bw; bw_next = alu_y[1] | (~alu_y[0] & bw).
REQ-024 After bit W-1 -> RESP; latency accept-to-rsp_valid = W+1 cycles for supported ops, 1 for rejected.
REQ-025 RESP: rsp_valid=1, outputs stable until rsp_ready=1; on handshake -> IDLE; no request accepted same cycle.
REQ-026 Outside RUN: alu_a=0, alu_b=0, alu_ctrl=4'b0000; alu_y ignored.
REQ-027 Result width modulo 2^W; overflow shown only via rsp_carry.

Reset
REQ-028 rst_n low: immediately IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_err=0, alu_* = 0.
REQ-029 Reset mid-RUN or in RESP discards the operation; no response emitted.
REQ-030 Leaving reset: first request accepted on first rising edge with rst_n high.

Configuration
REQ-031 Macro ALU_SERIAL_CTRL_ARITH_EN defined: ADD/SUB supported as REQ-022/023; undefined: 0111 and 1000 treated as unsupported (REQ-018), carry logic absent, rsp_carry tied 0.

Structure
REQ-032 Shared package alu_pkg holds the 4-bit opcode constants, opcode typedef, and FSM state typedef.
REQ-033 Single module; no sub-module; the external 1-bit ALU is instantiated by the bench/top, not inside.

Verification (bench instantiates the 1-bit ALU on alu_a/alu_b/alu_ctrl/alu_y, W=8)
REQ-034 op=0101, a=8'hF0, b=8'h3C -> rsp_result=8'hCC, rsp_err=0, rsp_valid 9 cycles after accept.
REQ-035 ARITH_EN: op=0111, a=8'hFF, b=8'h01 -> rsp_result=8'h00, rsp_carry=1.
REQ-036 ARITH_EN: op=1000, a=8'h05, b=8'h07 -> rsp_result=8'hFE, rsp_carry=1; without macro -> rsp_err=1, result 0, after 1 cycle.
REQ-037 op=1001 -> rsp_err=1, rsp_result=0, alu_ctrl stays 0000 throughout.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0; then release -> IDLE, next request accepted.
REQ-039 rst_n pulsed low at bit 3 of RUN -> outputs at reset values immediately, no rsp_valid afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, opcode type and FSM state type for the serial ALU controller.
// ALU_SERIAL_CTRL_ARITH_EN adds ADD/SUB to the supported opcode set.
package alu_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_AND  = 4'b0000;
  localparam op_t OP_OR   = 4'b0001;
  localparam op_t OP_NOTA = 4'b0010;
  localparam op_t OP_NAND = 4'b0011;
  localparam op_t OP_NOR  = 4'b0100;
  localparam op_t OP_XOR  = 4'b0101;
  localparam op_t OP_XNOR = 4'b0110;
  localparam op_t OP_ADD  = 4'b0111;
  localparam op_t OP_SUB  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RESP
  } state_t;

  function automatic logic op_supported(input op_t op);
`ifdef ALU_SERIAL_CTRL_ARITH_EN
    return (op <= OP_SUB);
`else
    return (op <= OP_XNOR);
`endif
  endfunction

endpackage

// File: rtl/alu_serial_ctrl.sv
// Bit-serial W-bit ALU sequencer driving an external 1-bit ALU, LSB first.
// ALU_SERIAL_CTRL_ARITH_EN enables ADD/SUB with carry/borrow chaining; otherwise rsp_carry is 0.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready=1
// RUN     | one operand bit per cycle through the external ALU
// RESP    | response held until rsp_ready
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         alu_a,
  output logic         alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [1:0]   alu_y,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_err
);

  localparam int CW = $clog2(W);

  state_t         state;
  op_t            op_q;
  logic [W-1:0]   a_q, b_q, res_q;
  logic [CW-1:0]  cnt;
  logic           bit_out;
  logic [W-1:0]   res_next;

  assign req_ready = (state == ST_IDLE);
  assign alu_a     = (state == ST_RUN) & a_q[0];
  assign alu_b     = (state == ST_RUN) & b_q[0];
  assign alu_ctrl  = (state == ST_RUN) ? op_q : 4'b0000;

`ifdef ALU_SERIAL_CTRL_ARITH_EN
  logic cy_q, cy_next;

  always_comb begin
    bit_out = alu_y[0];
    cy_next = 1'b0;
    if (op_q == OP_ADD) begin
      bit_out = alu_y[0] ^ cy_q;
      cy_next = alu_y[1] | (alu_y[0] & cy_q);
    end else if (op_q == OP_SUB) begin
      bit_out = alu_y[0] ^ cy_q;
      cy_next = alu_y[1] | (~alu_y[0] & cy_q);
    end
  end
`else
  // The external ALU's carry bit has no consumer when only bitwise ops exist.
  logic unused_alu_y1;
  assign unused_alu_y1 = alu_y[1];
  assign bit_out       = alu_y[0];
  assign rsp_carry     = 1'b0;
`endif

  assign res_next = {bit_out, res_q[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_AND;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
`ifdef ALU_SERIAL_CTRL_ARITH_EN
      cy_q       <= 1'b0;
      rsp_carry  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (op_supported(req_op)) begin
              op_q  <= req_op;
              a_q   <= req_a;
              b_q   <= req_b;
              cnt   <= CW'(W - 1);
`ifdef ALU_SERIAL_CTRL_ARITH_EN
              cy_q  <= 1'b0;
`endif
              state <= ST_RUN;
            end else begin
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
`ifdef ALU_SERIAL_CTRL_ARITH_EN
              rsp_carry  <= 1'b0;
`endif
              state      <= ST_RESP;
            end
          end
        end
        ST_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_next;
`ifdef ALU_SERIAL_CTRL_ARITH_EN
          cy_q  <= cy_next;
`endif
          if (cnt == '0) begin
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            rsp_result <= res_next;
`ifdef ALU_SERIAL_CTRL_ARITH_EN
            rsp_carry  <= cy_next;
`endif
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (W=8) with a behavioural 1-bit ALU and word-level reference model.
// Honours ALU_SERIAL_CTRL_ARITH_EN the same way the design does.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         alu_a, alu_b;
  logic [3:0]   alu_ctrl;
  logic [1:0]   alu_y;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_err;

  int errors = 0;
  int checks = 0;

  alu_serial_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External 1-bit ALU: y[0] is the per-bit function, y[1] the generate/borrow-generate term.
  always_comb begin
    alu_y = 2'b00;
    case (alu_ctrl)
      4'd0: alu_y = {1'b0, alu_a & alu_b};
      4'd1: alu_y = {1'b0, alu_a | alu_b};
      4'd2: alu_y = {1'b0, ~alu_a};
      4'd3: alu_y = {1'b0, ~(alu_a & alu_b)};
      4'd4: alu_y = {1'b0, ~(alu_a | alu_b)};
      4'd5: alu_y = {1'b0, alu_a ^ alu_b};
      4'd6: alu_y = {1'b0, ~(alu_a ^ alu_b)};
      4'd7: alu_y = {alu_a & alu_b, alu_a ^ alu_b};
      4'd8: alu_y = {~alu_a & alu_b, alu_a ^ alu_b};
      default: alu_y = 2'b00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: plain arithmetic on whole operands.
  task automatic ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] res, output logic cy, output logic err);
    logic [W:0] wide;
    res = '0; cy = 1'b0; err = 1'b0; wide = '0;
    case (op)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: res = ~a;
      4'd3: res = ~(a & b);
      4'd4: res = ~(a | b);
      4'd5: res = a ^ b;
      4'd6: res = ~(a ^ b);
`ifdef ALU_SERIAL_CTRL_ARITH_EN
      4'd7: begin wide = {1'b0, a} + {1'b0, b}; res = wide[W-1:0]; cy = wide[W]; end
      4'd8: begin res = a - b; cy = (a < b); end
`endif
      default: err = 1'b1;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [W-1:0] e_res;
    logic         e_cy, e_err;
    int           lat;
    logic         ctrl_leak;
    logic [W-1:0] r0;
    logic         c0, e0, changed;
    ref_model(op, a, b, e_res, e_cy, e_err);
    @(negedge clk);
    chk({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    ctrl_leak = (alu_ctrl != 4'b0000);
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), e_err ? 32'd1 : 32'(W + 1));
    chk({tag, ".result"}, 32'(rsp_result), 32'(e_res));
    chk({tag, ".carry"}, 32'(rsp_carry), 32'(e_cy));
    chk({tag, ".err"}, 32'(rsp_err), 32'(e_err));
    chk({tag, ".req_ready_resp"}, 32'(req_ready), 32'd0);
    if (e_err) chk({tag, ".alu_ctrl_idle"}, 32'(ctrl_leak || alu_ctrl != 4'b0000), 32'd0);
    if (hold > 0) begin
      r0 = rsp_result; c0 = rsp_carry; e0 = rsp_err; changed = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!rsp_valid || req_ready || rsp_result !== r0 || rsp_carry !== c0 || rsp_err !== e0)
          changed = 1'b1;
      end
      chk({tag, ".held_stable"}, 32'(changed), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] rop;
    logic       seen_valid;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #12;
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_result", 32'(rsp_result), 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.alu_outs", 32'({alu_a, alu_b, alu_ctrl}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("xor_f0_3c", 4'b0101, 8'hF0, 8'h3C, 0);
    chk("xor_expect_cc", 32'(rsp_result), 32'h00CC);
    run_op("add_ff_01", 4'b0111, 8'hFF, 8'h01, 0);
    run_op("sub_05_07", 4'b1000, 8'h05, 8'h07, 0);
    run_op("op_1001", 4'b1001, 8'hAA, 8'h55, 0);
    run_op("backpressure", 4'b0000, 8'hCA, 8'h5F, 5);
    run_op("after_bp", 4'b0010, 8'h0F, 8'h00, 0);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 15));
      run_op("random", rop, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset while bit 3 is being presented to the external ALU.
    run_op("pre_reset", 4'b0101, 8'hF0, 8'h3C, 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0001; req_a = 8'h96; req_b = 8'h69;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("midrun.alu_ctrl", 32'(alu_ctrl), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst.req_ready", 32'(req_ready), 32'd1);
    chk("midrun_rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrun_rst.rsp_result", 32'(rsp_result), 32'd0);
    chk("midrun_rst.carry_err", 32'({rsp_carry, rsp_err}), 32'd0);
    chk("midrun_rst.alu_outs", 32'({alu_a, alu_b, alu_ctrl}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_valid = 1'b1;
    end
    chk("midrun_rst.no_rsp", 32'(seen_valid), 32'd0);
    run_op("post_reset", 4'b0110, 8'h3C, 8'hA5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
